tea_ctr_stream: RTL and testbench

//  Streaming TEA counter-mode engine: XORs a stream of 64-bit blocks with the keystream
//  TEA_enc(key, counter_block), where counter_block advances by one per block. Successor
//  of the single-shot tea_ctr: adds valid/ready handshakes, packet framing, configurable

---
 rtl/tea_pkg.sv | 36 +++
 rtl/tea_round.sv | 37 +++
 rtl/tea_ctr_stream.sv | 185 ++++++++++++++++++
 tb/tb_tea_ctr_stream.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared definitions for the streaming TEA counter-mode engine.
// Contents:
//   TEA_DELTA       - TEA key-schedule constant added to sum once per cycle
//   state_t         - engine FSM encoding (IDLE / RUN / HOLD)
//   key_word()      - picks k0..k3 out of the 128-bit key (k0 = key[127:96])
//   blk_hi/blk_lo() - splits a 64-bit block into v0 (upper) / v1 (lower)
package tea_pkg;

    localparam logic [31:0] TEA_DELTA = 32'h9E37_79B9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic [31:0] key_word(input logic [127:0] key, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = key[127:96];
            2'd1:    w = key[95:64];
            2'd2:    w = key[63:32];
            default: w = key[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [31:0] blk_hi(input logic [63:0] blk);
        return blk[63:32];
    endfunction

    function automatic logic [31:0] blk_lo(input logic [63:0] blk);
        return blk[31:0];
    endfunction

endpackage

// File: rtl/tea_round.sv
// One TEA cycle (a Feistel round pair), purely combinational.
// Ports:
//   i_v0, i_v1 - block halves entering the cycle
//   i_sum      - running sum before this cycle (delta is added here first)
//   i_key      - 128-bit key, k0 = i_key[127:96]
//   o_v0, o_v1 - block halves after the cycle
//   o_sum      - updated running sum, fed to the next chained instance
module tea_round
    import tea_pkg::*;
(
    input  logic [31:0]  i_v0,
    input  logic [31:0]  i_v1,
    input  logic [31:0]  i_sum,
    input  logic [127:0] i_key,
    output logic [31:0]  o_v0,
    output logic [31:0]  o_v1,
    output logic [31:0]  o_sum
);

    logic [31:0] w_sum;
    logic [31:0] w_v0;

    assign w_sum = i_sum + TEA_DELTA;

    // The second half-round uses the already-updated v0.
    assign w_v0 = i_v0 + (((i_v1 << 4) + key_word(i_key, 2'd0)) ^
                          (i_v1 + w_sum) ^
                          ((i_v1 >> 5) + key_word(i_key, 2'd1)));

    assign o_v1 = i_v1 + (((w_v0 << 4) + key_word(i_key, 2'd2)) ^
                          (w_v0 + w_sum) ^
                          ((w_v0 >> 5) + key_word(i_key, 2'd3)));

    assign o_v0  = w_v0;
    assign o_sum = w_sum;

endmodule

// File: rtl/tea_ctr_stream.sv
// Streaming TEA counter-mode engine: out_data = in_data ^ TEA_enc(key, counter_block),
// with the counter block's low CTR_W bits advancing by one per block of a packet.
// Encrypt and decrypt are the same operation.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid, once raised, holds with its payload stable until that transfer.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   cfg_load            - latch key/nonce and restart block index (IDLE only)
//   key, nonce          - configuration, sampled only with cfg_load
//   in_valid/in_ready   - input block handshake; in_data, in_last payload
//   out_valid/out_ready - result handshake; out_data, out_last payload
//   busy                - engine not in IDLE
//   ctr_wrap            - sticky, low counter field wrapped since last cfg_load
//   dbg_state           - current FSM state encoding
module tea_ctr_stream
    import tea_pkg::*;
#(
    parameter int ROUNDS = 32,
    parameter int UNROLL = 1,
    parameter int CTR_W  = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_load,
    input  logic [127:0] key,
    input  logic [63:0]  nonce,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         out_last,
    output logic         busy,
    output logic         ctr_wrap,
    output logic [1:0]   dbg_state
);

    localparam int N_CLK  = ROUNDS / UNROLL;
    localparam int RCNT_W = (N_CLK > 1) ? $clog2(N_CLK) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(N_CLK - 1);
    // Selects the incrementing low field of the counter block.
    localparam logic [63:0] CTR_MASK = (CTR_W >= 64) ? {64{1'b1}} :
                                       ((64'd1 << CTR_W) - 64'd1);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_rdy_en;     // holds in_ready low until the first edge after reset
    logic [127:0]        r_key;
    logic [63:0]         r_nonce;
    logic [63:0]         r_blk_idx;
    logic [63:0]         r_data;
    logic                r_last;
    logic [31:0]         r_v0;
    logic [31:0]         r_v1;
    logic [31:0]         r_sum;
    logic [RCNT_W-1:0]   r_rcnt;
    logic                r_out_valid;
    logic [63:0]         r_out_data;
    logic                r_out_last;
    logic                r_ctr_wrap;

    logic                w_accept;
    logic [63:0]         w_ctr_blk;
    logic [63:0]         w_blk_next;
    logic                w_lo_zero_next;

    logic [31:0]         w_v0  [0:UNROLL];
    logic [31:0]         w_v1  [0:UNROLL];
    logic [31:0]         w_sum [0:UNROLL];

    // Round chain: UNROLL TEA cycles evaluated per clock.
    assign w_v0[0]  = r_v0;
    assign w_v1[0]  = r_v1;
    assign w_sum[0] = r_sum;

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        tea_round u_round (
            .i_v0  (w_v0[g]),
            .i_v1  (w_v1[g]),
            .i_sum (w_sum[g]),
            .i_key (r_key),
            .o_v0  (w_v0[g+1]),
            .o_v1  (w_v1[g+1]),
            .o_sum (w_sum[g+1])
        );
    end

    // Low field adds modulo 2^CTR_W; upper nonce bits never see a carry.
    assign w_ctr_blk      = (r_nonce & ~CTR_MASK) | ((r_nonce + r_blk_idx) & CTR_MASK);
    assign w_blk_next     = (r_blk_idx + 64'd1) & CTR_MASK;
    assign w_lo_zero_next = (((r_nonce + w_blk_next) & CTR_MASK) == 64'd0);

    // cfg_load wins over an input block in IDLE.
    assign in_ready = r_rdy_en && (r_state == ST_IDLE) && !cfg_load;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)              w_state_next = ST_RUN;
            ST_RUN:  if (r_rcnt == RCNT_LAST)   w_state_next = ST_HOLD;
            ST_HOLD: if (out_ready)             w_state_next = ST_IDLE;
            default:                            w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_en    <= 1'b0;
            r_key       <= '0;
            r_nonce     <= '0;
            r_blk_idx   <= '0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_v0        <= '0;
            r_v1        <= '0;
            r_sum       <= '0;
            r_rcnt      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_ctr_wrap  <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_load) begin
                        r_key      <= key;
                        r_nonce    <= nonce;
                        r_blk_idx  <= '0;
                        r_ctr_wrap <= 1'b0;
                    end else if (w_accept) begin
                        r_data <= in_data;
                        r_last <= in_last;
                        r_v0   <= blk_hi(w_ctr_blk);
                        r_v1   <= blk_lo(w_ctr_blk);
                        r_sum  <= '0;
                        r_rcnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_v0   <= w_v0[UNROLL];
                    r_v1   <= w_v1[UNROLL];
                    r_sum  <= w_sum[UNROLL];
                    r_rcnt <= r_rcnt + 1'b1;
                    if (r_rcnt == RCNT_LAST) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_data ^ {w_v0[UNROLL], w_v1[UNROLL]};
                        r_out_last  <= r_last;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_blk_idx <= '0;
                        end else begin
                            r_blk_idx <= w_blk_next;
                            if (w_lo_zero_next) r_ctr_wrap <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = (r_state != ST_IDLE);
    assign ctr_wrap  = r_ctr_wrap;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_tea_ctr_stream.sv
// Bench for tea_ctr_stream: four instances (default, CTR_W=4, UNROLL=4, UNROLL=32)
// driven by directed tasks, checked every cycle against a transaction-level model.
module tb_tea_ctr_stream;

    localparam int ND = 4;
    localparam logic [63:0] KAT0 = 64'h41EA3A0A94BAA940;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst       [ND];
    logic         cfg_load  [ND];
    logic [127:0] key       [ND];
    logic [63:0]  nonce     [ND];
    logic         in_valid  [ND];
    logic         in_ready  [ND];
    logic [63:0]  in_data   [ND];
    logic         in_last   [ND];
    logic         out_valid [ND];
    logic         out_ready [ND];
    logic [63:0]  out_data  [ND];
    logic         out_last  [ND];
    logic         busy      [ND];
    logic         ctr_wrap  [ND];
    logic [1:0]   dbg_state [ND];

    tea_ctr_stream #(.ROUNDS(32), .UNROLL(1), .CTR_W(32)) u_dut0 (
        .clk(clk), .rst(rst[0]), .cfg_load(cfg_load[0]), .key(key[0]), .nonce(nonce[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]),
        .busy(busy[0]), .ctr_wrap(ctr_wrap[0]), .dbg_state(dbg_state[0]));
    tea_ctr_stream #(.ROUNDS(32), .UNROLL(1), .CTR_W(4)) u_dut1 (
        .clk(clk), .rst(rst[1]), .cfg_load(cfg_load[1]), .key(key[1]), .nonce(nonce[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]),
        .busy(busy[1]), .ctr_wrap(ctr_wrap[1]), .dbg_state(dbg_state[1]));
    tea_ctr_stream #(.ROUNDS(32), .UNROLL(4), .CTR_W(32)) u_dut2 (
        .clk(clk), .rst(rst[2]), .cfg_load(cfg_load[2]), .key(key[2]), .nonce(nonce[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_last(in_last[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .out_last(out_last[2]),
        .busy(busy[2]), .ctr_wrap(ctr_wrap[2]), .dbg_state(dbg_state[2]));
    tea_ctr_stream #(.ROUNDS(32), .UNROLL(32), .CTR_W(32)) u_dut3 (
        .clk(clk), .rst(rst[3]), .cfg_load(cfg_load[3]), .key(key[3]), .nonce(nonce[3]),
        .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[3]), .in_last(in_last[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]), .out_last(out_last[3]),
        .busy(busy[3]), .ctr_wrap(ctr_wrap[3]), .dbg_state(dbg_state[3]));

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int ncyc(input int d);
        case (d)
            2:       return 8;
            3:       return 1;
            default: return 32;
        endcase
    endfunction

    function automatic logic [63:0] lo_mask(input int d);
        return (d == 1) ? 64'h0000_0000_0000_000F : 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Reference TEA encryption, 32 cycles, straight from the algorithm description.
    function automatic logic [63:0] tea_enc(input logic [127:0] k, input logic [63:0] b);
        logic [31:0] v0, v1, s, k0, k1, k2, k3;
        v0 = b[63:32]; v1 = b[31:0]; s = 32'd0;
        k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
        for (int i = 0; i < 32; i++) begin
            s  = s + 32'h9E3779B9;
            v0 = v0 + (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
            v1 = v1 + (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
        end
        return {v0, v1};
    endfunction

    // ---------------- transaction model / scoreboard ----------------
    bit           m_busy   [ND];
    bit           m_rdy_en [ND];
    bit           m_wrap   [ND];
    logic [127:0] m_key    [ND];
    logic [63:0]  m_nonce  [ND];
    logic [63:0]  m_idx    [ND];
    longint       m_acc    [ND];
    longint       ecnt = 0;
    logic [64:0]  exp_q    [ND][$];   // {last, data}

    function automatic logic [63:0] ctr_block(input int d);
        logic [63:0] msk;
        msk = lo_mask(d);
        return (m_nonce[d] & ~msk) | ((m_nonce[d] + m_idx[d]) & msk);
    endfunction

    bit          v_pre, r_pre;
    logic [64:0] ent;

    always @(posedge clk) begin
        ecnt = ecnt + 1;
        for (int d = 0; d < ND; d++) begin
            if (rst[d]) begin
                m_busy[d] = 0; m_rdy_en[d] = 0; m_wrap[d] = 0;
                m_key[d] = '0; m_nonce[d] = '0; m_idx[d] = '0;
                exp_q[d].delete();
            end else begin
                v_pre = m_busy[d] && ((ecnt - 1) >= m_acc[d] + ncyc(d));
                r_pre = m_rdy_en[d] && !m_busy[d] && !cfg_load[d];
                if (v_pre && out_ready[d]) begin
                    ent = exp_q[d].pop_front();
                    m_busy[d] = 0;
                    if (ent[64]) begin
                        m_idx[d] = '0;
                    end else begin
                        m_idx[d] = (m_idx[d] + 64'd1) & lo_mask(d);
                        if (((m_nonce[d] + m_idx[d]) & lo_mask(d)) == 64'd0) m_wrap[d] = 1;
                    end
                end else if (!m_busy[d] && cfg_load[d]) begin
                    m_key[d] = key[d]; m_nonce[d] = nonce[d]; m_idx[d] = '0; m_wrap[d] = 0;
                end else if (r_pre && in_valid[d]) begin
                    m_busy[d] = 1;
                    m_acc[d]  = ecnt;
                    exp_q[d].push_back({in_last[d], in_data[d] ^ tea_enc(m_key[d], ctr_block(d))});
                end
                m_rdy_en[d] = 1;
            end
        end
    end

    // Every-cycle compare, 2 time units after the active edge.
    bit e_v, e_r;
    always @(posedge clk) begin
        #2;
        for (int d = 0; d < ND; d++) begin
            e_v = m_busy[d] && (ecnt >= m_acc[d] + ncyc(d));
            e_r = m_rdy_en[d] && !m_busy[d] && !cfg_load[d];
            chk($sformatf("in_ready%0d", d),  64'(in_ready[d]),  64'(e_r));
            chk($sformatf("out_valid%0d", d), 64'(out_valid[d]), 64'(e_v));
            chk($sformatf("busy%0d", d),      64'(busy[d]),      64'(m_busy[d]));
            chk($sformatf("ctr_wrap%0d", d),  64'(ctr_wrap[d]),  64'(m_wrap[d]));
            if (e_v && exp_q[d].size() > 0) begin
                chk($sformatf("out_data%0d", d), out_data[d], exp_q[d][0][63:0]);
                chk($sformatf("out_last%0d", d), 64'(out_last[d]), 64'(exp_q[d][0][64]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int d);
        @(negedge clk); rst[d] = 1'b1;
        repeat (2) @(negedge clk);
        rst[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_cfg(input int d, input logic [127:0] k, input logic [63:0] n);
        @(negedge clk);
        cfg_load[d] = 1'b1; key[d] = k; nonce[d] = n;
        @(negedge clk);
        cfg_load[d] = 1'b0;
    endtask

    task automatic send_blk(input int d, input logic [63:0] data, input logic last);
        int n;
        @(negedge clk);
        in_valid[d] = 1'b1; in_data[d] = data; in_last[d] = last;
        n = 0;
        while (!in_ready[d] && n < 200) begin @(negedge clk); n++; end
        n_checks++;
        if (n >= 200) begin n_err++; $display("FAIL send_timeout dut=%0d actual=no_ready required=ready", d); end
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    task automatic recv_blk(input int d, output logic [63:0] data, output logic last, output int lat);
        int n;
        n = 0;
        while (!out_valid[d] && n < 200) begin @(negedge clk); n++; end
        n_checks++;
        if (n >= 200) begin n_err++; $display("FAIL recv_timeout dut=%0d actual=no_valid required=valid", d); end
        data = out_data[d]; last = out_last[d]; lat = n;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    logic [127:0] kk;
    logic [63:0]  nn, d0, rd;
    logic [63:0]  pt [3];
    logic [63:0]  ct [3];
    logic         rl;
    int           lat;

    initial begin
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1; cfg_load[d] = 1'b0; key[d] = '0; nonce[d] = '0;
            in_valid[d] = 1'b0; in_data[d] = '0; in_last[d] = 1'b0; out_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("rst_in_ready", 64'(in_ready[d]), 64'd0);
            chk("rst_out_data", out_data[d], 64'd0);
            chk("rst_out_last", 64'(out_last[d]), 64'd0);
        end
        for (int d = 0; d < ND; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) chk("rel_in_ready", 64'(in_ready[d]), 64'd1);

        // All-zero known-answer vector, default / UNROLL=4 / UNROLL=32.
        for (int d = 0; d < ND; d++) begin
            if (d != 1) begin
                do_cfg(d, '0, '0);
                send_blk(d, 64'd0, 1'b1);
                recv_blk(d, rd, rl, lat);
                chk($sformatf("kat_data%0d", d), rd, KAT0);
                chk($sformatf("kat_last%0d", d), 64'(rl), 64'd1);
                chk($sformatf("kat_lat%0d", d), 64'(lat), 64'(ncyc(d)));
            end
        end

        // Round trip of a 3-block packet.
        kk = 128'h0123456789ABCDEF0123456789ABCDEF;
        nn = 64'h1234567890ABCDEF;
        pt[0] = 64'h0011223344556677; pt[1] = 64'hDEADBEEFCAFEF00D; pt[2] = 64'hFFFFFFFF00000000;
        do_cfg(0, kk, nn);
        for (int i = 0; i < 3; i++) begin
            send_blk(0, pt[i], (i == 2));
            recv_blk(0, ct[i], rl, lat);
        end
        chk("rt_ct0", ct[0], pt[0] ^ tea_enc(kk, 64'h1234567890ABCDEF));
        chk("rt_ct2", ct[2], pt[2] ^ tea_enc(kk, 64'h1234567890ABCDF1));
        do_cfg(0, kk, nn);
        for (int i = 0; i < 3; i++) begin
            send_blk(0, ct[i], (i == 2));
            recv_blk(0, rd, rl, lat);
            chk($sformatf("rt_plain%0d", i), rd, pt[i]);
        end

        // Counter wrap with a 4-bit low field.
        do_cfg(1, kk, 64'h0123456789ABCDEF);
        send_blk(1, 64'd0, 1'b0);
        recv_blk(1, rd, rl, lat);
        chk("wrap_blk0", rd, tea_enc(kk, 64'h0123456789ABCDEF));
        chk("wrap_flag", 64'(ctr_wrap[1]), 64'd1);
        send_blk(1, 64'd0, 1'b1);
        recv_blk(1, rd, rl, lat);
        chk("wrap_blk1", rd, tea_enc(kk, 64'h0123456789ABCDE0));
        do_cfg(1, kk, 64'h0123456789ABCDEF);
        chk("wrap_clear", 64'(ctr_wrap[1]), 64'd0);

        // Backpressure: hold the result for 10 clocks.
        do_cfg(0, kk, nn);
        out_ready[0] = 1'b0;
        send_blk(0, pt[0], 1'b0);
        recv_blk(0, d0, rl, lat);   // no transfer: out_ready is low
        chk("bp_data", d0, pt[0] ^ tea_enc(kk, 64'h1234567890ABCDEF));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_data", out_data[0], d0);
            chk("bp_hold_valid", 64'(out_valid[0]), 64'd1);
            chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_released", 64'(out_valid[0]), 64'd0);
        send_blk(0, pt[1], 1'b1);
        recv_blk(0, rd, rl, lat);
        chk("bp_next", rd, pt[1] ^ tea_enc(kk, 64'h1234567890ABCDF0));

        // cfg_load during RUN is ignored.
        do_cfg(0, kk, nn);
        send_blk(0, pt[0], 1'b1);
        repeat (5) @(negedge clk);
        cfg_load[0] = 1'b1; key[0] = ~kk; nonce[0] = 64'd0;
        @(negedge clk);
        cfg_load[0] = 1'b0;
        recv_blk(0, rd, rl, lat);
        chk("cfg_run_ign0", rd, pt[0] ^ tea_enc(kk, nn));
        send_blk(0, pt[1], 1'b1);
        recv_blk(0, rd, rl, lat);
        chk("cfg_run_ign1", rd, pt[1] ^ tea_enc(kk, nn));

        // Reset mid-RUN discards the block and clears the configuration.
        send_blk(0, pt[2], 1'b1);
        repeat (5) @(negedge clk);
        do_reset(0);
        repeat (40) @(negedge clk);
        chk("rst_run_busy", 64'(busy[0]), 64'd0);
        chk("rst_run_valid", 64'(out_valid[0]), 64'd0);
        send_blk(0, 64'd0, 1'b1);
        recv_blk(0, rd, rl, lat);
        chk("rst_run_kat", rd, KAT0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
